// File: rtl/instruction_fetch_pkg.sv
// Shared encodings for the IF stage: FSM states and the special HALT/NOP instruction words.
// Imported by the fetch top and anything that inspects its state (debug unit).
package instruction_fetch_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam logic [31:0] HALT_WORD = 32'hFFFFFFFF;
   localparam logic [31:0] NOP_WORD  = 32'h00000000;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed RAM: synchronous write, combinational read, contents not reset.
// Shared by instruction fetch and the debug unit's read-back path.
module instruction_memory #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 8
) (
   input  logic               clk,
   input  logic               i_we,
   input  logic [NB_ADDR-1:0] i_waddr,
   input  logic [NB_DATA-1:0] i_wdata,
   input  logic [NB_ADDR-1:0] i_raddr,
   output logic [NB_DATA-1:0] o_rdata
);

   logic [NB_DATA-1:0] mem_q [2**NB_ADDR];

   always_ff @(posedge clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC, loader-filled instruction memory and IF/ID register; one cycle PC->o_instruction.
// Priority in run: halt freezes all, stall holds PC and IF/ID, jump flushes with NOP, else fetch.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int                  NB_DATA      = 32,
   parameter int                  NB_IMEM_ADDR = 8,
   parameter logic [NB_DATA-1:0]  NOP          = NB_DATA'(NOP_WORD)
) (
   input  logic                    clk,
   input  logic                    i_rst_n,
   input  logic                    i_load_we,
   input  logic [NB_IMEM_ADDR-1:0] i_load_addr,
   input  logic [NB_DATA-1:0]      i_load_data,
   input  logic                    i_start,
   input  logic                    i_stall,
   input  logic                    i_halt,
   input  logic                    i_jump,
   input  logic [NB_DATA-1:0]      i_addr2jump,
   output logic [NB_DATA-1:0]      o_instruction,
   output logic [NB_DATA-1:0]      o_pcounter4,
   output logic [NB_DATA-1:0]      o_pc,
   output logic                    o_running,
   output logic                    o_done
);

   state_e             state_q, state_d;
   logic [NB_DATA-1:0] pc_q, pc_d;
   logic [NB_DATA-1:0] instr_q, instr_d;
   logic [NB_DATA-1:0] pc4_q, pc4_d;
   logic               running_q, running_d;
   logic               done_q, done_d;

   logic [NB_DATA-1:0] fetch_word;
   logic [NB_DATA-1:0] pc_plus4;
   logic               mem_we;

   // The loader only owns the memory while the program is not executing.
   assign mem_we   = i_load_we && (state_q == ST_LOAD);
   assign pc_plus4 = pc_q + NB_DATA'(4);

   instruction_memory #(
      .NB_DATA (NB_DATA),
      .NB_ADDR (NB_IMEM_ADDR)
   ) u_imem (
      .clk     (clk),
      .i_we    (mem_we),
      .i_waddr (i_load_addr),
      .i_wdata (i_load_data),
      .i_raddr (pc_q[NB_IMEM_ADDR+1:2]),
      .o_rdata (fetch_word)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      case (state_q)
         ST_LOAD: begin
            pc_d    = '0;
            instr_d = NOP;
            pc4_d   = '0;
            if (i_start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // A jump raised during a stall is dropped; decode re-asserts it afterwards.
            if (!i_halt && !i_stall) begin
               if (i_jump) begin
                  pc_d    = i_addr2jump;
                  instr_d = NOP;
                  pc4_d   = '0;
               end else begin
                  instr_d = fetch_word;
                  pc4_d   = pc_plus4;
                  if (fetch_word == NB_DATA'(HALT_WORD)) begin
                     state_d = ST_DONE;
                  end else begin
                     pc_d = pc_plus4;
                  end
               end
            end
         end
         ST_DONE: begin
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
      running_d = (state_d == ST_RUN);
      done_d    = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_LOAD;
         pc_q      <= '0;
         instr_q   <= NOP;
         pc4_q     <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         pc4_q     <= pc4_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end

   assign o_instruction = instr_q;
   assign o_pcounter4   = pc4_q;
   assign o_pc          = pc_q;
   assign o_running     = running_q;
   assign o_done        = done_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations plus
// randomized episodes, all outputs compared every cycle against a behavioural model.
module tb_instruction_fetch;

   logic        clk;
   logic        i_rst_n;
   logic        i_load_we;
   logic [7:0]  i_load_addr;
   logic [31:0] i_load_data;
   logic        i_start;
   logic        i_stall;
   logic        i_halt;
   logic        i_jump;
   logic [31:0] i_addr2jump;
   logic [31:0] o_instruction;
   logic [31:0] o_pcounter4;
   logic [31:0] o_pc;
   logic        o_running;
   logic        o_done;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 0;

   logic [31:0] prog [256];

   // Behavioural model: program memory plus architectural PC, IF/ID and run/done flags.
   logic [31:0] m_mem [256];
   logic [31:0] m_pc   = 0;
   logic [31:0] m_ins  = 0;
   logic [31:0] m_pc4  = 0;
   logic        m_run  = 0;
   logic        m_done = 0;

   instruction_fetch dut (
      .clk           (clk),
      .i_rst_n       (i_rst_n),
      .i_load_we     (i_load_we),
      .i_load_addr   (i_load_addr),
      .i_load_data   (i_load_data),
      .i_start       (i_start),
      .i_stall       (i_stall),
      .i_halt        (i_halt),
      .i_jump        (i_jump),
      .i_addr2jump   (i_addr2jump),
      .o_instruction (o_instruction),
      .o_pcounter4   (o_pcounter4),
      .o_pc          (o_pc),
      .o_running     (o_running),
      .o_done        (o_done)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] word_of(input logic [31:0] byte_addr);
      return 8'((byte_addr >> 2) % 32'd256);
   endfunction

   always @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         m_pc   <= 0;
         m_ins  <= 0;
         m_pc4  <= 0;
         m_run  <= 0;
         m_done <= 0;
      end else if (!m_run && !m_done) begin
         if (i_load_we) m_mem[i_load_addr] <= i_load_data;
         if (i_start) m_run <= 1;
      end else if (m_run && !i_halt && !i_stall) begin
         if (i_jump) begin
            m_pc  <= i_addr2jump;
            m_ins <= 0;
            m_pc4 <= 0;
         end else begin
            m_ins <= m_mem[word_of(m_pc)];
            m_pc4 <= 32'(m_pc + 32'd4);
            if (m_mem[word_of(m_pc)] == 32'hFFFFFFFF) begin
               m_run  <= 0;
               m_done <= 1;
            end else begin
               m_pc <= 32'(m_pc + 32'd4);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model instruction", o_instruction, m_ins);
         chk("model pcounter4",   o_pcounter4,   m_pc4);
         chk("model pc",          o_pc,          m_pc);
         chk("model running",     32'(o_running), 32'(m_run));
         chk("model done",        32'(o_done),    32'(m_done));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_inputs();
      i_load_we   = 0;
      i_load_addr = 0;
      i_load_data = 0;
      i_start     = 0;
      i_stall     = 0;
      i_halt      = 0;
      i_jump      = 0;
      i_addr2jump = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      i_rst_n = 0;
      step(1);
      i_rst_n = 1;
   endtask

   task automatic load_word(input logic [7:0] a, input logic [31:0] d);
      i_load_we   = 1;
      i_load_addr = a;
      i_load_data = d;
      step(1);
      i_load_we = 0;
   endtask

   task automatic start_run();
      i_start = 1;
      step(1);
      i_start = 0;
   endtask

   task automatic jump_to(input logic [31:0] a);
      i_jump      = 1;
      i_addr2jump = a;
      step(1);
      i_jump = 0;
   endtask

   task automatic chk_if(input string nm, input logic [31:0] ins, input logic [31:0] p4,
                         input logic [31:0] pc);
      chk({nm, " instruction"}, o_instruction, ins);
      chk({nm, " pcounter4"},   o_pcounter4,   p4);
      chk({nm, " pc"},          o_pc,          pc);
   endtask

   initial begin
      logic [31:0] exp_ins [4];
      logic [31:0] w;
      exp_ins = '{32'h24010001, 32'h24020002, 32'h24030003, 32'hFFFFFFFF};

      idle_inputs();
      i_rst_n = 0;
      step(1);
      chk_if("reset", 32'h0, 32'h0, 32'h0);
      chk("reset running", 32'(o_running), 32'd0);
      chk("reset done",    32'(o_done),    32'd0);
      i_rst_n = 1;
      cmp_en  = 1;

      // Fill the whole memory so later jumps never read unloaded words.
      for (int a = 0; a < 256; a++) begin
         if (a < 4) begin
            w = exp_ins[a];
         end else begin
            w = $urandom;
            if (w == 32'hFFFFFFFF) w = 32'h1234_5678;
         end
         prog[a] = w;
         load_word(8'(a), w);
      end
      chk_if("load holds pc", 32'h0, 32'h0, 32'h0);

      // Straight-line program ending in HALT.
      start_run();
      chk("start running", 32'(o_running), 32'd1);
      for (int k = 0; k < 4; k++) begin
         step(1);
         chk_if("seq", exp_ins[k], 32'(4 * (k + 1)), (k < 3) ? 32'(4 * (k + 1)) : 32'd12);
      end
      chk("halt done", 32'(o_done), 32'd1);
      i_jump      = 1;
      i_stall     = 1;
      i_addr2jump = 32'h40;
      step(3);
      idle_inputs();
      chk_if("done frozen", 32'hFFFFFFFF, 32'd16, 32'd12);

      // Jump flush: NOP bubble, then target word with target+4.
      do_reset();
      start_run();
      step(2);
      chk("jump pre pc", o_pc, 32'h8);
      jump_to(32'h20);
      chk_if("jump flush", 32'h0, 32'h0, 32'h20);
      step(1);
      chk_if("jump target", prog[8], 32'h24, 32'h24);

      // Stall holds PC and IF/ID; jump during stall is dropped.
      do_reset();
      start_run();
      step(1);
      for (int k = 0; k < 3; k++) begin
         i_stall     = 1;
         i_jump      = (k != 1);
         i_addr2jump = 32'h80;
         step(1);
         chk_if("stall", 32'h24010001, 32'h4, 32'h4);
      end
      idle_inputs();
      step(1);
      chk_if("stall release", 32'h24020002, 32'h8, 32'h8);

      // Debug halt freezes everything, then fetching resumes in place.
      jump_to(32'h40);
      step(1);
      chk_if("pre halt", prog[16], 32'h44, 32'h44);
      for (int k = 0; k < 5; k++) begin
         i_halt      = 1;
         i_jump      = k[0];
         i_stall     = k[1];
         i_addr2jump = 32'h100;
         step(1);
         chk_if("halt", prog[16], 32'h44, 32'h44);
      end
      idle_inputs();
      step(1);
      chk_if("halt release", prog[17], 32'h48, 32'h48);

      // Loader writes while running must not reach memory.
      load_word(8'h00, 32'hDEADBEEF);
      do_reset();
      start_run();
      step(1);
      chk_if("run write ignored", 32'h24010001, 32'h4, 32'h4);

      // Asynchronous reset in mid-cycle, rerun without reload, address wrap.
      jump_to(32'h10);
      chk("pre reset pc", o_pc, 32'h10);
      #3;
      i_rst_n = 0;
      #1;
      chk_if("async reset", 32'h0, 32'h0, 32'h0);
      chk("async reset running", 32'(o_running), 32'd0);
      step(1);
      i_rst_n = 1;
      start_run();
      step(1);
      chk_if("rerun", 32'h24010001, 32'h4, 32'h4);
      jump_to(32'h400);
      chk_if("wrap flush", 32'h0, 32'h0, 32'h400);
      step(1);
      chk_if("wrap fetch", 32'h24010001, 32'h404, 32'h404);

      // Randomized episodes checked by the model every cycle.
      for (int ep = 0; ep < 20; ep++) begin
         do_reset();
         for (int n = 0; n < 10; n++) begin
            w = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF : $urandom;
            load_word(8'($urandom_range(0, 255)), w);
         end
         start_run();
         for (int c = 0; c < 200; c++) begin
            i_halt      = ($urandom_range(0, 7) == 0);
            i_stall     = ($urandom_range(0, 4) == 0);
            i_jump      = ($urandom_range(0, 5) == 0);
            i_addr2jump = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            i_load_we   = ($urandom_range(0, 3) == 0);
            i_load_addr = 8'($urandom);
            i_load_data = $urandom;
            i_start     = $urandom_range(0, 1) == 1;
            step(1);
         end
         idle_inputs();
         step(1);
      end

      cmp_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
